// File: rtl/mem_pkg.sv
// Shared definitions for the data memory responder and the processor decode.
// Holds the responder FSM state encoding, the default storage depth and the
// load/store opcode constants.
package mem_pkg;

    localparam int unsigned DEPTH_DEFAULT = 64;

    // Major opcodes shared with the processor decode stage.
    localparam logic [5:0] OPC_LW = 6'd35;
    localparam logic [5:0] OPC_SW = 6'd43;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RESPOND = 2'd2
    } state_e;

    function automatic logic addr_misaligned(input logic [1:0] byte_off);
        return byte_off != 2'b00;
    endfunction

endpackage

// File: rtl/data_mem_responder_word_store.sv
// word_store: DEPTH x 32-bit storage array.
// Ports:
//   clk    - clock, all updates on rising edge
//   clr    - synchronous clear of every word (wins over a write)
//   we     - write enable
//   waddr  - write word index
//   wdata  - write data
//   raddr  - read word index
//   rdata  - combinational read data
module word_store
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             we,
    input  logic [IDX_W-1:0] waddr,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] raddr,
    output logic [31:0]      rdata
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: serialized load/store responder in front of a word store.
// One request is in flight at a time: IDLE accepts, ACCESS performs the
// checked read or write, RESPOND holds the result until it is taken.
// Ports:
//   clk, rst              - clock and synchronous active-high reset
//   req_valid/req_ready   - request handshake
//   req_write             - 1 = store, 0 = load
//   req_addr              - byte address (word index = req_addr[ADDR_W-1:2])
//   req_wdata             - store data
//   rsp_valid/rsp_ready   - response handshake
//   rsp_rdata             - load data, 0 for stores and errors
//   rsp_err               - misaligned or out-of-range request
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEFAULT,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    state_e            state_q, state_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    logic [ADDR_W-3:0] word_idx;
    logic [IDX_W-1:0]  mem_idx;
    logic              out_of_range;
    logic              acc_err;
    logic              mem_we;
    logic [31:0]       mem_rdata;

    assign word_idx = addr_q[ADDR_W-1:2];
    assign mem_idx  = IDX_W'(word_idx);

    // Any set bit above the index width means word index >= DEPTH; such
    // addresses must error rather than alias onto a low word.
    assign out_of_range = (word_idx >> IDX_W) != '0;
    assign acc_err      = addr_misaligned(addr_q[1:0]) || out_of_range;

    word_store #(
        .DEPTH(DEPTH)
    ) u_store (
        .clk  (clk),
        .clr  (rst),
        .we   (mem_we),
        .waddr(mem_idx),
        .wdata(wdata_q),
        .raddr(mem_idx),
        .rdata(mem_rdata)
    );

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_we      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                rsp_err_d   = acc_err;
                rsp_rdata_d = (!write_q && !acc_err) ? mem_rdata : '0;
                // A reset in this cycle clears the store, overriding the write.
                mem_we      = write_q && !acc_err;
                state_d     = ST_RESPOND;
            end
            ST_RESPOND: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESPOND);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed scoreboard bench for data_mem_responder.
module tb_data_mem_responder;

    localparam int unsigned DEPTH  = 64;
    localparam int unsigned ADDR_W = 32;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    int          tests = 0;
    int          fails = 0;
    int unsigned cyc   = 0;
    logic [31:0] model_mem [DEPTH];
    exp_t        sb [$];

    data_mem_responder #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic model_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= DEPTH);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = '0;
        sb.delete();
    endtask

    // Present a request at a negedge, wait (bounded) for acceptance, update the
    // reference model and push the expected response. Returns at the negedge
    // following the accepting edge (DUT in ACCESS).
    task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input bit keep, output int unsigned acc_cyc);
        exp_t        e;
        int unsigned idx;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
        check("accept_ready", {31'b0, req_ready}, 32'd1);
        acc_cyc = 0;
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        e.err   = model_err(a);
        idx     = a >> 2;
        e.rdata = '0;
        if (!e.err) begin
            if (w) model_mem[idx] = d;
            else   e.rdata = model_mem[idx];
        end
        sb.push_back(e);
        @(negedge clk);
        acc_cyc = cyc;
        if (!keep) begin
            req_valid = 1'b0;
            req_write = 1'($urandom);
            req_addr  = $urandom;
            req_wdata = $urandom;
        end
    endtask

    // Called in the ACCESS cycle. Checks latency, compares against the
    // scoreboard, optionally withholds rsp_ready for 'hold' cycles, then
    // completes the handshake. Returns at the negedge in IDLE.
    task automatic expect_rsp(input int unsigned hold);
        exp_t e;
        check("lat_access_valid", {31'b0, rsp_valid}, 32'd0);
        if (hold > 0) rsp_ready = 1'b0;
        @(negedge clk);
        check("lat_respond_valid", {31'b0, rsp_valid}, 32'd1);
        check("sb_nonempty", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (sb.size() == 0) begin
            rsp_ready = 1'b1;
            @(negedge clk);
            return;
        end
        e = sb.pop_front();
        check("rsp_rdata", rsp_rdata, e.rdata);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        for (int i = 0; i < int'(hold); i++) begin
            @(negedge clk);
            check("bp_valid", {31'b0, rsp_valid}, 32'd1);
            check("bp_rdata", rsp_rdata, e.rdata);
            check("bp_err", {31'b0, rsp_err}, {31'b0, e.err});
            check("bp_req_ready", {31'b0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("idle_req_ready", {31'b0, req_ready}, 32'd1);
    endtask

    initial begin
        int unsigned t0, t1, t2, t3;
        rst       = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        model_clear();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);

        // Fresh storage reads zero
        send(1'b0, 32'h40, 32'h0, 1'b0, t0); expect_rsp(0);

        // Store then load
        send(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, t0); expect_rsp(0);
        send(1'b0, 32'h10, 32'h0, 1'b0, t0); expect_rsp(0);

        // Misaligned store leaves storage unchanged
        send(1'b1, 32'h12, 32'h1, 1'b0, t0); expect_rsp(0);
        send(1'b0, 32'h10, 32'h0, 1'b0, t0); expect_rsp(0);
        send(1'b0, 32'h13, 32'h0, 1'b0, t0); expect_rsp(0);

        // Range boundaries: last word, first out-of-range word, high bit set
        send(1'b1, 32'hFC, 32'hA5A5A5A5, 1'b0, t0); expect_rsp(0);
        send(1'b0, 32'hFC, 32'h0, 1'b0, t0); expect_rsp(0);
        send(1'b0, 32'h100, 32'h0, 1'b0, t0); expect_rsp(0);
        send(1'b1, 32'h80000010, 32'h77777777, 1'b0, t0); expect_rsp(0);
        send(1'b0, 32'h10, 32'h0, 1'b0, t0); expect_rsp(0);

        // Backpressure with a second request waiting
        send(1'b0, 32'h10, 32'h0, 1'b0, t0);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'hCAFE0001;
        expect_rsp(5);
        send(1'b1, 32'h20, 32'hCAFE0001, 1'b0, t1);
        check("bp_accept_gap", t1 - t0, 32'd8);
        expect_rsp(0);
        send(1'b0, 32'h20, 32'h0, 1'b0, t0); expect_rsp(0);

        // Back-to-back with valid held high and rsp_ready tied to 1
        send(1'b1, 32'h8, 32'h11112222, 1'b1, t0); expect_rsp(0);
        send(1'b0, 32'h8, 32'h0, 1'b1, t1); expect_rsp(0);
        send(1'b1, 32'hC, 32'h33334444, 1'b1, t2); expect_rsp(0);
        send(1'b0, 32'hC, 32'h0, 1'b1, t3); expect_rsp(0);
        req_valid = 1'b0;
        check("b2b_gap1", t1 - t0, 32'd3);
        check("b2b_gap2", t2 - t1, 32'd3);
        check("b2b_gap3", t3 - t2, 32'd3);

        // Reset during the ACCESS cycle of a store
        send(1'b1, 32'h4, 32'h55, 1'b0, t0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        check("rst_acc_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_acc_req_ready", {31'b0, req_ready}, 32'd1);
        send(1'b0, 32'h4, 32'h0, 1'b0, t0); expect_rsp(0);
        send(1'b0, 32'h8, 32'h0, 1'b0, t0); expect_rsp(0);

        // Reset during RESPOND drops the pending response
        send(1'b1, 32'h18, 32'h9999AAAA, 1'b0, t0);
        rsp_ready = 1'b0;
        @(negedge clk);
        check("pre_rst_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        model_clear();
        check("rst_rsp_drop_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_drop_err", {31'b0, rsp_err}, 32'd0);
        check("rst_rsp_drop_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_drop_ready", {31'b0, req_ready}, 32'd1);
        send(1'b0, 32'h18, 32'h0, 1'b0, t0); expect_rsp(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
